// File: rtl/prio_arbiter_8.sv
// 8-requester arbiter with registered one-hot grant, hold limit and one dead cycle between owners.
// Define ARB_ROUND_ROBIN_EN to rotate priority after each grant; otherwise fixed priority, index 7 highest.
module prio_arbiter_8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       rel,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_vld,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam bit               LIMIT_EN  = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state_reg;
  logic [2:0]       owner_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       win_id;
  logic             owner_drop;
  logic             limit_hit;
  logic             release_now;

`ifdef ARB_ROUND_ROBIN_EN
  logic [2:0] last_id;
  logic [7:0] rot_req;

  // rot_req[k] is the requester visited (k+1)-th, starting just below last_id.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
      assign rot_req[gi] = req[3'(last_id - 3'(gi) - 3'd1)];
    end
  endgenerate

  always_comb begin
    win_id = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (rot_req[k]) win_id = 3'(last_id - 3'(k) - 3'd1);
    end
  end
`else
  always_comb begin
    win_id = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) win_id = 3'(i);
    end
  end
`endif

  assign owner_drop  = !req[owner_reg];
  assign limit_hit   = LIMIT_EN && (cnt_reg == LIMIT_CNT);
  assign release_now = rel || owner_drop || limit_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      owner_reg <= 3'd0;
      cnt_reg   <= '0;
      gnt       <= 8'h00;
      gnt_id    <= 3'd0;
      gnt_vld   <= 1'b0;
      timeout   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_id   <= 3'd0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          timeout <= 1'b0;
          if (req != 8'h00) begin
            state_reg <= GRANT;
            owner_reg <= win_id;
            cnt_reg   <= '0;
            gnt       <= 8'h01 << win_id;
            gnt_id    <= win_id;
            gnt_vld   <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            last_id   <= win_id;
`endif
          end
        end
        GRANT: begin
          if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + 1'b1;
          if (release_now) begin
            state_reg <= IDLE;
            gnt       <= 8'h00;
            gnt_id    <= 3'd0;
            gnt_vld   <= 1'b0;
            // A release or request drop in the same cycle outranks the limit.
            timeout   <= limit_hit && !rel && !owner_drop;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prio_arbiter_8.sv
// Randomized bench for prio_arbiter_8 against an ownership-level model, plus directed literal checks.
// Honours ARB_ROUND_ROBIN_EN the same way the design does.
module tb_prio_arbiter_8;

  localparam int MH = 4;

`ifdef ARB_ROUND_ROBIN_EN
  localparam int E2 = 2;
  localparam int E3 = 1;
`else
  localparam int E2 = 5;
  localparam int E3 = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       rel;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_vld;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  // model state: who owns the resource and for how many cycles so far
  bit m_busy = 1'b0;
  int m_owner = 0;
  int m_len = 0;
  int m_last = 0;
  bit m_to = 1'b0;

  prio_arbiter_8 #(.MAX_HOLD(MH), .CNT_W(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .rel     (rel),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [7:0] r, input int last);
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 8; k++) begin
      if (r[(last - k + 8) % 8]) return (last - k + 8) % 8;
    end
`else
    for (int i = 7; i >= 0; i--) begin
      if (r[i]) return i;
    end
`endif
    return 0;
  endfunction

  // Reference model: advances on each edge from the inputs held across it.
  initial begin
    bit ended;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 1'b0; m_owner = 0; m_len = 0; m_last = 0; m_to = 1'b0;
      end else if (!m_busy) begin
        m_to = 1'b0;
        if (req != 8'h00) begin
          m_owner = pick(req, m_last);
          m_last  = m_owner;
          m_busy  = 1'b1;
          m_len   = 1;
        end
      end else begin
        ended = rel || !req[m_owner] || (m_len >= MH);
        m_to  = ended && !rel && req[m_owner];
        if (ended) m_busy = 1'b0;
        else m_len++;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    bit prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      chk("gnt", int'(gnt), m_busy ? (1 << m_owner) : 0);
      chk("gnt_id", int'(gnt_id), m_busy ? m_owner : 0);
      chk("gnt_vld", int'(gnt_vld), int'(m_busy));
      chk("timeout", int'(timeout), int'(m_to));
      if (gnt_vld && !prev_vld) $display("grant id=%0d t=%0t", gnt_id, $time);
      prev_vld = gnt_vld;
    end
  end

  initial begin
    rst_n = 1'b0; req = 8'h00; rel = 1'b0;
    tick(); tick();
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_vld", int'(gnt_vld), 0);
    chk("rst_to", int'(timeout), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_noreq", int'(gnt_vld), 0);

    // priority selection, dead cycle between owners
    req = 8'b0010_0110;
    tick(); chk("prio_first", int'(gnt_id), 5);
    rel = 1'b1;
    tick(); chk("prio_dead", int'(gnt_vld), 0);
    rel = 1'b0;
    tick(); chk("prio_second", int'(gnt_id), E2);
    rel = 1'b1;
    tick(); chk("prio_dead2", int'(gnt), 0);
    rel = 1'b0; req = 8'b0000_0110;
    tick(); chk("prio_third", int'(gnt_id), E3);
    req = 8'h00;
    tick(); chk("drop_gnt", int'(gnt), 0);
    chk("drop_to", int'(timeout), 0);
    tick(); chk("drop_nogrant", int'(gnt_vld), 0);

    // hold limit
    req = 8'h80;
    tick(); chk("hold_c1", int'(gnt), 8'h80);
    tick(); chk("hold_c2", int'(gnt_vld), 1);
    tick(); chk("hold_c3", int'(gnt_vld), 1);
    tick(); chk("hold_c4", int'(gnt_vld), 1);
    tick(); chk("hold_end", int'(gnt_vld), 0);
    chk("hold_timeout", int'(timeout), 1);
    tick(); chk("hold_regrant", int'(gnt), 8'h80);
    chk("hold_to_clr", int'(timeout), 0);
    req = 8'h00;
    tick(); tick();

    // no preemption
    req = 8'h02;
    tick(); chk("npre_own", int'(gnt), 8'h02);
    req = 8'h82;
    tick(); chk("npre_hold", int'(gnt), 8'h02);
    rel = 1'b1;
    tick(); chk("npre_dead", int'(gnt), 0);
    rel = 1'b0;
    tick(); chk("npre_next", int'(gnt), 8'h80);
    req = 8'h00;
    tick(); tick();

    // asynchronous reset mid-grant
    req = 8'h10;
    tick(); chk("arst_own", int'(gnt), 8'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", int'(gnt), 0);
    chk("arst_vld", int'(gnt_vld), 0);
    chk("arst_id", int'(gnt_id), 0);
    tick();
    rst_n = 1'b1; req = 8'h00;
    tick();

`ifdef ARB_ROUND_ROBIN_EN
    req = 8'hFF; rel = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick(); chk("rr_order", int'(gnt_id), (15 - k) % 8);
      tick(); chk("rr_dead", int'(gnt_vld), 0);
    end
`else
    req = 8'hFF; rel = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(); chk("fp_all", int'(gnt_id), 7);
      tick(); chk("fp_dead", int'(gnt_vld), 0);
    end
`endif
    req = 8'h00; rel = 1'b0;
    tick(); tick();

    // randomized traffic, occasional async reset
    for (int n = 0; n < 2000; n++) begin
      int r;
      tick();
      if (!rst_n) rst_n = 1'b1;
      r = $urandom_range(0, 9);
      if (r >= 6 && r < 9) req = 8'($urandom);
      else if (r == 9) req = (($urandom_range(0, 1) == 0) ? 8'h00 : (req ^ (8'h01 << $urandom_range(0, 7))));
      rel = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
      end
    end
    rst_n = 1'b1;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prio_arbiter_8.md
# prio_arbiter_8

Sequential 8-requester arbiter that grants a single shared resource using the team's 8-to-3 priority encoding (index 7 highest by default). It registers a one-hot grant plus encoded owner ID, holds the grant until the owner releases, drops its request, or exceeds a hold limit, and inserts one dead cycle between owners. It sits in front of any shared datapath resource (bus, memory port, ALU) whose users are identified by a 3-bit index.

## Interface
- MAX_HOLD, 16: maximum consecutive grant cycles per ownership; 0 disables the limit.
- CNT_W, 5: hold counter width; must satisfy 2^CNT_W > MAX_HOLD.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- req  input  8  request vector; req[i] high = requester i wants the resource.
- rel  input  1  release strobe from the current owner; ignored when no grant is active.
- gnt  output  8  registered one-hot grant; all-zero when idle.
- gnt_id  output  3  registered index of the current owner; 0 when idle.
- gnt_vld  output  1  registered; high exactly when gnt != 0.
- timeout  output  1  registered one-cycle pulse: the previous grant ended by the hold limit.

## Operation
- FSM states: IDLE, GRANT. Reset state IDLE.
- IDLE: gnt=0, gnt_vld=0, gnt_id=0. If req != 0, select winner w from req and go to GRANT; owner register = w, hold counter = 0.
- Winner selection (fixed priority): highest set index wins (req=8'b0010_0110 -> w=5).
- GRANT: gnt = 1<<owner, gnt_id = owner, gnt_vld=1; hold counter increments every GRANT cycle (saturates, never wraps).
- Release condition, evaluated each GRANT cycle: rel=1, OR req[owner]=0, OR (MAX_HOLD!=0 AND counter == MAX_HOLD-1). Any true -> next state IDLE.
- Higher-priority requests arriving during GRANT never preempt the owner.
- timeout asserts in the first IDLE cycle only when the hold limit was the sole cause (rel=0 and req[owner]=1); rel or request drop in the same cycle as the limit takes precedence, timeout=0.
- Requests from other indices during GRANT are not latched; req is re-sampled in IDLE.
- rst_n low at any time, including mid-grant: all outputs and state clear immediately (asynchronously); first arbitration occurs on the first rising edge with rst_n high.

## Timing
- Reset values: gnt=8'h00, gnt_id=3'd0, gnt_vld=0, timeout=0, state IDLE, counter 0, RR pointer 0.
- Grant latency: req sampled high in IDLE on edge N -> gnt visible after edge N (one clock from req present to gnt).
- Release: release condition true at edge M -> gnt=0 after edge M (IDLE cycle); new winner sampled at edge M+1, granted after M+1. Minimum one dead cycle between any two grants, including re-grant to the same requester.
- Hold limit: maximum MAX_HOLD consecutive cycles with gnt_vld=1 per ownership.
- rel pulse lasting several cycles: only the GRANT cycle matters; rel high in IDLE has no effect.
- All outputs are flop-driven; no combinational path from req/rel to outputs.

## Configuration
- ARB_ROUND_ROBIN_EN defined: a 3-bit pointer last_id (reset 0) is loaded with owner on every grant. Search order is last_id-1, last_id-2, ... wrapping modulo 8, last_id searched last. With last_id=0 the order is 7..0, identical to fixed priority, so the first arbitration after reset matches the undefined build.
- ARB_ROUND_ROBIN_EN undefined: pure fixed priority, index 7 highest; pointer logic absent.

## Test plan
- Reset mid-grant: owner 4 granted, pull rst_n low between edges -> gnt=0, gnt_vld=0, gnt_id=0 immediately, before next edge.
- Fixed priority: req=8'b0010_0110 held, rel pulse each grant -> grants 5, (dead), 5 ... ; with req dropping bit 5 after release -> next grant 2.
- Hold limit: MAX_HOLD=4, req=8'h80 constant, rel=0 -> gnt_vld high 4 cycles, low 1 cycle with timeout=1, then re-granted to 7.
- Request drop: owner 3, req[3] falls at edge M -> gnt=0 after M, timeout=0, no grant if req=0.
- No preemption: owner 1, assert req[7] mid-grant -> gnt stays 8'h02 until rel, then 8'h80 after one dead cycle.
- ARB_ROUND_ROBIN_EN: req=8'hFF constant, rel every grant cycle -> grant order 7,6,5,4,3,2,1,0,7 with one dead cycle between each.
